// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default operand width for the sequential multiplier.
package mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 32;
endpackage

// File: rtl/mult_step.sv
// mult_step: one add-and-shift step over the {carry, upper, multiplier} accumulator.
module mult_step import mult_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic [WIDTH-1:0]  a,
  output logic [2*WIDTH:0]  acc_next
);
  logic [WIDTH:0] upper;
  always_comb begin
    upper    = acc[0] ? {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a} : acc[2*WIDTH:WIDTH];
    acc_next = {1'b0, upper, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier, WIDTH steps plus one DONE cycle.
// Signed operands are supported when MULT_SIGNED_EN is defined.
module mult_seq import mult_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               start,
`ifdef MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d, a_mag, b_mag;
  logic [2*WIDTH:0]     acc_q, acc_d, acc_step;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 neg_q, neg_d, a_neg, b_neg;
`ifdef MULT_SIGNED_EN
  assign a_neg = signed_mode & a_in[WIDTH-1];
  assign b_neg = signed_mode & b_in[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  // Magnitudes fit WIDTH bits unsigned, so the most negative value stays exact.
  assign a_mag = a_neg ? -a_in : a_in;
  assign b_mag = b_neg ? -b_in : b_in;
  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .acc_next (acc_step)
  );
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    neg_d     = neg_q;
    if (state_q == IDLE && start) begin
      state_d = CALC;
      a_d     = a_mag;
      acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
      cnt_d   = '0;
      neg_d   = a_neg ^ b_neg;
    end else if (state_q == CALC) begin
      if (cnt_q == CW'(WIDTH)) begin
        state_d   = DONE;
        product_d = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
      end else begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      neg_q     <= neg_d;
    end
  end
  assign product = product_q;
  assign done    = state_q == DONE;
  assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed and random checks of mult_seq at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_mult_seq;
`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_in = '0, b_in = '0;
  logic        start32 = 1'b0, start8 = 1'b0, sm = 1'b0;
  logic [63:0] product32;
  logic [15:0] product8;
  logic        done32, busy32, done8, busy8;
  int          vectors = 0, fails = 0;
  logic [63:0] last32 = '0;
  logic [15:0] last8 = '0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .start(start32),
`ifdef MULT_SIGNED_EN
    .signed_mode(sm),
`endif
    .product(product32), .done(done32), .busy(busy32)
  );

  mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .a_in(a_in[7:0]), .b_in(b_in[7:0]), .start(start8),
`ifdef MULT_SIGNED_EN
    .signed_mode(sm),
`endif
    .product(product8), .done(done8), .busy(busy8)
  );

  function automatic logic [127:0] model(input logic [63:0] a, b, input int w, input bit sg);
    logic [127:0] ax, bx, p;
    ax = {64'b0, a};
    bx = {64'b0, b};
    if (sg && a[w-1]) ax = ax | ({128{1'b1}} << w);
    if (sg && b[w-1]) bx = bx | ({128{1'b1}} << w);
    p = ax * bx;
    return p & ~({128{1'b1}} << (2 * w));
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic [31:0] a, b, input bit s, input int inj, input string tag);
    logic [63:0] exp;
    int n;
    exp = 64'(model({32'b0, a}, {32'b0, b}, 32, SIGNED_EN && s));
    @(negedge clk);
    a_in = a; b_in = b; sm = s; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    n = 0;
    while (!done32 && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (n == inj) begin
        a_in = 32'd100; b_in = 32'd100; sm = ~s; start32 = 1'b1;
      end else start32 = 1'b0;
      if (n == 10) chk({tag, " held_in_calc"}, 128'(product32), 128'(last32));
    end
    chk({tag, " latency"}, 128'(n), 128'd33);
    chk({tag, " product"}, 128'(product32), 128'(exp));
    chk({tag, " busy_at_done"}, 128'(busy32), 128'd1);
    @(posedge clk); #1;
    chk({tag, " busy_after"}, 128'(busy32), 128'd0);
    chk({tag, " done_after"}, 128'(done32), 128'd0);
    chk({tag, " product_held"}, 128'(product32), 128'(exp));
    last32 = exp;
  endtask

  task automatic run8(input logic [7:0] a, b, input bit s, input string tag);
    logic [15:0] exp;
    int n;
    exp = 16'(model({56'b0, a}, {56'b0, b}, 8, SIGNED_EN && s));
    @(negedge clk);
    a_in = {24'b0, a}; b_in = {24'b0, b}; sm = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency8"}, 128'(n), 128'd9);
    chk({tag, " product8"}, 128'(product8), 128'(exp));
    @(posedge clk); #1;
    chk({tag, " busy8_after"}, 128'(busy8), 128'd0);
    last8 = exp;
  endtask

  initial begin
    int n, seen;
    #12;
    chk("reset product", 128'(product32), 128'd0);
    chk("reset busy", 128'(busy32), 128'd0);
    chk("reset done", 128'(done32), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    run32(32'd3, 32'd5, 1'b0, -1, "3x5");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, "max_sq");
    chk("max_sq const", 128'(last32), 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001);
    run32(32'd0, 32'hDEAD_BEEF, 1'b0, -1, "zero");
    if (SIGNED_EN) begin
      run32(32'hFFFF_FFFD, 32'd5, 1'b1, -1, "neg3x5");
      chk("neg3x5 const", 128'(last32), 128'hFFFF_FFFF_FFFF_FFF1);
      run32(32'h8000_0000, 32'h8000_0000, 1'b1, -1, "minsq");
      chk("minsq const", 128'(last32), 128'h4000_0000_0000_0000);
    end
    run32(32'd7, 32'd9, 1'b0, 5, "ignore_start");
    chk("ignore_start const", 128'(last32), 128'd63);
    // Abort an operation after its tenth step with an asynchronous reset.
    @(negedge clk);
    a_in = 32'd7; b_in = 32'd3; sm = 1'b0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort product", 128'(product32), 128'd0);
    chk("abort done", 128'(done32), 128'd0);
    chk("abort busy", 128'(busy32), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    last32 = '0;
    last8 = '0;
    seen = 0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done32 || busy32) seen++;
    end
    chk("abort no_done", 128'(seen), 128'd0);
    run32(32'd2, 32'd2, 1'b0, -1, "after_abort");
    run8(8'hFF, 8'hFF, 1'b0, "w8_max");
    chk("w8_max const", 128'(last8), 128'hFE01);
    if (SIGNED_EN) run8(8'h80, 8'h7F, 1'b1, "w8_signed");
    for (int i = 0; i < 12; i++)
      run32($urandom, $urandom, 1'($urandom_range(0, 1)), -1, "rand32");
    for (int i = 0; i < 10; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand8");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port a_in  input  WIDTH  multiplicand, sampled only on the start-accepting edge.
REQ-005 SHALL have port b_in  input  WIDTH  multiplier, sampled only on the start-accepting edge.
REQ-006 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-007 SHALL have port signed_mode  input  1  1=two's-complement operands; present only under MULT_SIGNED_EN.
REQ-008 SHALL have port product  output  2*WIDTH  result, held stable from done until the next accepted start.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking product valid.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; busy = (state != IDLE).
REQ-012 SHALL, at an edge in IDLE with start=1, latch operands, clear the accumulator, zero step count and go to CALC.
REQ-013 SHALL perform exactly one combined add-and-shift step per CALC cycle: if multiplier LSB=1, add multiplicand into upper half with carry; then shift the full 2*WIDTH+1 accumulator right by 1.
REQ-014 SHALL leave CALC after exactly WIDTH steps, load product and assert done for the one DONE cycle, then return to IDLE.
REQ-015 SHALL give a latency of WIDTH+1 edges: start accepted at edge E, done high after edge E+WIDTH+1, busy low after edge E+WIDTH+2.
REQ-016 SHALL ignore start while busy=1; operands and progress are unaffected.
REQ-017 SHALL allow a start in the cycle after DONE (IDLE) so back-to-back operations lose no more than one idle cycle.
REQ-018 SHALL keep the add carry (no overflow loss); the full 2*WIDTH-bit product is exact for all operand values.
REQ-019 SHALL keep product unchanged during CALC; product updates only when entering DONE.
REQ-020 SHALL tie the step counter width to $clog2(WIDTH+1) and wrap it to zero on each accepted start.

Reset
REQ-021 SHALL, on reset asserted at any time, including mid-CALC, immediately force state=IDLE, product=0, done=0, busy=0, counter and accumulator=0.
REQ-022 SHALL abort an in-flight operation on reset; no done pulse is produced for it.
REQ-023 SHALL accept start on the first rising edge after reset deasserts.

Configuration
REQ-024 SHALL, with MULT_SIGNED_EN defined, expose signed_mode; when 1 at accept, multiply operand magnitudes and negate the 2*WIDTH result if the operand signs differ; -2^(WIDTH-1) SHALL be handled exactly.
REQ-025 SHALL, without MULT_SIGNED_EN, omit signed_mode and treat all operands as unsigned, with identical latency.
REQ-026 SHALL keep latency identical in both modes; sign fix-up occurs combinationally on the DONE load.

Structure
REQ-027 SHALL place the state enum (IDLE/CALC/DONE) and a default-width constant in package mult_pkg.
REQ-028 SHALL implement the combinational add-and-shift step as sub-module mult_step, parameterised by WIDTH.
REQ-029 SHALL contain no other sub-modules; FSM, counter and registers live in mult_seq.

Verification
REQ-030 SHALL check, at WIDTH=32, unsigned: a=3, b=5, start pulse -> done 33 edges later, product=15, busy low the following cycle.
REQ-031 SHALL check 0xFFFFFFFF*0xFFFFFFFF -> product=0xFFFFFFFE00000001.
REQ-032 SHALL check, with MULT_SIGNED_EN: signed_mode=1, a=-3, b=5 -> product=0xFFFFFFFFFFFFFFF1; a=0x80000000, b=0x80000000 -> 0x4000000000000000.
REQ-033 SHALL check a start with new operands pulsed mid-CALC -> ignored; the original 7*9 returns 63.
REQ-034 SHALL check reset asserted at step 10 -> all outputs 0 at once, no done; a new 2*2 after release -> 4.
REQ-035 SHALL check, at WIDTH=8: 0xFF*0xFF -> product=0xFE01 with done 9 edges after accept.
